// File: rtl/opsum_collector.sv
// Output-psum collector: issues (row,col) tags to the GON tag FIFO, drains GON words into the GLB.
// Optional build macro OPSUM_COLLECTOR_RELU_EN clamps negative signed 16-bit lanes to zero on capture.
module opsum_collector #(
    parameter int DATA_WIDTH_PSUM    = 64,
    parameter int ROW_TAG_WIDTH_PSUM = 4,
    parameter int COL_TAG_WIDTH_PSUM = 4,
    parameter int ADDR_WIDTH         = 12,
    parameter int PASS_WIDTH         = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ROW_TAG_WIDTH_PSUM-1:0] num_rows,
    input  logic [COL_TAG_WIDTH_PSUM-1:0] num_cols,
    input  logic [PASS_WIDTH-1:0]         num_passes,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    output logic [ROW_TAG_WIDTH_PSUM-1:0] opsum_row_tag,
    output logic [COL_TAG_WIDTH_PSUM-1:0] opsum_col_tag,
    output logic                          opsum_tags_wr_en,
    input  logic                          opsum_tags_full,
    input  logic [DATA_WIDTH_PSUM-1:0]    opsum_from_gon,
    input  logic                          opsum_gon_fifo_empty,
    output logic                          pop_opsum_from_gon,
    output logic                          glb_wr_en,
    output logic [ADDR_WIDTH-1:0]         glb_addr,
    output logic [DATA_WIDTH_PSUM-1:0]    glb_wdata,
    input  logic                          glb_ready,
    output logic                          busy,
    output logic                          done
);
    localparam int TOT_W = ROW_TAG_WIDTH_PSUM + COL_TAG_WIDTH_PSUM + PASS_WIDTH;
    localparam logic [ROW_TAG_WIDTH_PSUM-1:0] ROW_ONE = 1;
    localparam logic [COL_TAG_WIDTH_PSUM-1:0] COL_ONE = 1;
    localparam logic [TOT_W-1:0]              TOT_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [ROW_TAG_WIDTH_PSUM-1:0]   rows_q, rows_d, row_cnt_q, row_cnt_d;
    logic [COL_TAG_WIDTH_PSUM-1:0]   cols_q, cols_d, col_cnt_q, col_cnt_d;
    logic [ADDR_WIDTH-1:0]           base_q, base_d;
    logic [TOT_W-1:0]                total_q, total_d;
    logic [TOT_W-1:0]                tag_cnt_q, tag_cnt_d;
    logic [TOT_W-1:0]                pop_cnt_q, pop_cnt_d;
    logic [TOT_W-1:0]                acc_cnt_q, acc_cnt_d;
    logic                            out_vld_q, out_vld_d;
    logic [DATA_WIDTH_PSUM-1:0]      out_data_q, out_data_d;
    logic                            tag_en, pop_en, accept;
    logic [DATA_WIDTH_PSUM-1:0]      capture_word;

`ifdef OPSUM_COLLECTOR_RELU_EN
    function automatic logic [DATA_WIDTH_PSUM-1:0] relu_lanes(input logic [DATA_WIDTH_PSUM-1:0] w);
        logic [DATA_WIDTH_PSUM-1:0] r;
        r = w;
        for (int i = 0; i < DATA_WIDTH_PSUM / 16; i++) begin
            if (w[16*i+15]) r[16*i +: 16] = '0;
        end
        return r;
    endfunction
    assign capture_word = relu_lanes(opsum_from_gon);
`else
    assign capture_word = opsum_from_gon;
`endif

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        base_d     = base_q;
        total_d    = total_q;
        row_cnt_d  = row_cnt_q;
        col_cnt_d  = col_cnt_q;
        tag_cnt_d  = tag_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;

        // Tag issue and data drain are independent; the tags may run ahead of the data.
        tag_en = (state_q == RUN) && (tag_cnt_q != total_q) && !opsum_tags_full;
        accept = out_vld_q && glb_ready;
        pop_en = (state_q == RUN) && !opsum_gon_fifo_empty && (!out_vld_q || glb_ready)
                 && (pop_cnt_q != total_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d    = num_rows;
                    cols_d    = num_cols;
                    base_d    = base_addr;
                    total_d   = TOT_W'(num_rows) * TOT_W'(num_cols) * TOT_W'(num_passes);
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                    tag_cnt_d = '0;
                    pop_cnt_d = '0;
                    acc_cnt_d = '0;
                    out_vld_d = 1'b0;
                    if (num_rows == '0 || num_cols == '0 || num_passes == '0) state_d = DONE;
                    else state_d = RUN;
                end
            end
            RUN: begin
                if (tag_en) begin
                    tag_cnt_d = tag_cnt_q + TOT_ONE;
                    if (col_cnt_q == cols_q - COL_ONE) begin
                        col_cnt_d = '0;
                        row_cnt_d = (row_cnt_q == rows_q - ROW_ONE) ? '0 : row_cnt_q + ROW_ONE;
                    end else begin
                        col_cnt_d = col_cnt_q + COL_ONE;
                    end
                end
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + TOT_ONE;
                    out_vld_d = 1'b0;
                    if (acc_cnt_q == total_q - TOT_ONE) state_d = DONE;
                end
                if (pop_en) begin
                    pop_cnt_d  = pop_cnt_q + TOT_ONE;
                    out_vld_d  = 1'b1;
                    out_data_d = capture_word;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            base_q     <= '0;
            total_q    <= '0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            tag_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            acc_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            base_q     <= base_d;
            total_q    <= total_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            tag_cnt_q  <= tag_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign opsum_row_tag      = row_cnt_q;
    assign opsum_col_tag      = col_cnt_q;
    assign opsum_tags_wr_en   = tag_en;
    assign pop_opsum_from_gon = pop_en;
    assign glb_wr_en          = out_vld_q;
    assign glb_wdata          = out_data_q;
    // Address offset wraps naturally at the address width.
    assign glb_addr           = base_q + ADDR_WIDTH'(acc_cnt_q);
    assign busy               = (state_q == RUN) || (state_q == DONE);
    assign done               = (state_q == DONE);
endmodule

// File: doc/opsum_collector.md
OPSUM_COLLECTOR -- requirements
Module: opsum_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH_PSUM, default 64, meaning opsum word width (four 16-bit lanes).
REQ-002 SHALL have parameter ROW_TAG_WIDTH_PSUM, default 4, meaning opsum row tag width.
REQ-003 SHALL have parameter COL_TAG_WIDTH_PSUM, default 4, meaning opsum col tag width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 12, meaning global buffer address width.
REQ-005 SHALL have parameter PASS_WIDTH, default 8, meaning pass counter width.
REQ-006 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  in  1  one-cycle job launch pulse.
REQ-009 SHALL have ports num_rows  in  ROW_TAG_WIDTH_PSUM and num_cols  in  COL_TAG_WIDTH_PSUM, giving the tag sweep extent.
REQ-010 SHALL have ports num_passes  in  PASS_WIDTH and base_addr  in  ADDR_WIDTH, giving the repeat count and first write address.
REQ-011 SHALL have ports opsum_row_tag and opsum_col_tag  out  tag widths, and opsum_tags_wr_en  out  1, driving the GON tag FIFO.
REQ-012 SHALL have port opsum_tags_full  in  1  GON tag FIFO full.
REQ-013 SHALL have ports opsum_from_gon  in  DATA_WIDTH_PSUM, opsum_gon_fifo_empty  in  1, and pop_opsum_from_gon  out  1.
REQ-014 SHALL have ports glb_wr_en  out  1, glb_addr  out  ADDR_WIDTH, glb_wdata  out  DATA_WIDTH_PSUM, and glb_ready  in  1.
REQ-015 SHALL have ports busy  out  1 and done  out  1.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE when the last word is accepted by the GLB; DONE->IDLE after one cycle.
REQ-017 SHALL sample num_rows, num_cols, num_passes and base_addr on start, and SHALL ignore start outside IDLE.
REQ-018 SHALL go IDLE->DONE directly when any of num_rows, num_cols, num_passes is 0, with no tag writes or pops.
REQ-019 SHALL issue tags in RUN in row-major order (col fastest, then row, then pass), asserting opsum_tags_wr_en only when opsum_tags_full=0 and advancing on that cycle.
REQ-020 SHALL stop issuing after num_rows*num_cols*num_passes tags, and tag issue SHALL run ahead of data independently.
REQ-021 SHALL assert pop_opsum_from_gon only when opsum_gon_fifo_empty=0, the output register is empty or draining this cycle, and the popped count is below the total.
REQ-022 SHALL treat the GON as first-word-fall-through, capturing opsum_from_gon into the output register in the pop cycle.
REQ-023 SHALL present each output word with glb_wr_en=1 starting the cycle after the pop, holding glb_wdata and glb_addr stable until glb_ready=1.
REQ-024 SHALL allow a pop on the same cycle as the accepting glb_ready, giving one word per cycle sustained throughput.
REQ-025 SHALL set glb_addr to base_addr plus the count of words accepted so far, wrapping modulo 2^ADDR_WIDTH.
REQ-026 SHALL assert busy in RUN and DONE, and SHALL pulse done high for exactly one cycle in DONE.

Reset
REQ-027 SHALL, while reset=0 and at any time, including mid-job, force IDLE, zero all counters, and empty the output register.
REQ-028 SHALL hold every output at 0 during reset: opsum_row_tag, opsum_col_tag, opsum_tags_wr_en, pop_opsum_from_gon, glb_wr_en, glb_addr, glb_wdata, busy, done.

Configuration
REQ-029 SHALL, with OPSUM_COLLECTOR_RELU_EN defined, clamp each signed 16-bit lane of the captured word to 0 if negative before it reaches glb_wdata.
REQ-030 SHALL, without OPSUM_COLLECTOR_RELU_EN, pass words unmodified; latency and handshake SHALL be identical in both builds.

Verification
REQ-031 SHALL cover: rows=2, cols=3, passes=1, base=0x010, GON always non-empty, glb_ready=1 -> tags (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); 6 writes at 0x010..0x015; done pulses once.
REQ-032 SHALL cover: opsum_tags_full high cycles 2-5 of RUN -> no opsum_tags_wr_en in those cycles; the tag sequence resumes unchanged.
REQ-033 SHALL cover: glb_ready low 3 cycles with a word pending -> glb_wdata and glb_addr stable and no pop while blocked; no loss or duplication.
REQ-034 SHALL cover: base=0xFFE with 4 words -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-035 SHALL cover: reset low after 3 of 6 words -> all outputs 0 immediately; a following start with num_cols=0 -> done one cycle later with no traffic.
REQ-036 SHALL cover: RELU build with word 0xFFFF_0005_8000_7FFF -> glb_wdata 0x0000_0005_0000_7FFF; non-RELU build -> word unchanged.
